dmem_responder: RTL and testbench

- Data-memory target answering the dmem_* request interface driven by the pipeline's memory stage.
- Word-organised RAM with byte-lane writes and registered reads.
- Configurable wait states, a one-cycle completion pulse and error reporting.
- Sits between the MEM stage and the data RAM; returns full 32-bit words. Byte/half extraction and sign extension stay in the MEM stage.

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM-stage dmem_* interface: word RAM with byte-lane writes,
// registered reads, configurable wait states, a one-cycle ready pulse and error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_data_in,
    output logic        dmem_ready,
    output logic        dmem_error
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;

    logic [31:0] data_in_q;
    logic        ready_q, error_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic            from_idle;
    logic [29:0]     acc_word;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_rd, acc_wr;
    logic            acc_oob, acc_err;
    logic            enter_done, mem_we;
    logic [IdxW-1:0] acc_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^dmem_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (dmem_read | dmem_write) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With no wait states DONE is entered straight from IDLE, so the access uses live inputs.
    always_comb begin
        from_idle  = (state_q == StIdle);
        acc_word   = from_idle ? dmem_addr[31:2]  : word_q;
        acc_wdata  = from_idle ? dmem_data_out    : wdata_q;
        acc_be     = from_idle ? dmem_byte_enable : be_q;
        acc_rd     = from_idle ? dmem_read        : rd_q;
        acc_wr     = from_idle ? dmem_write       : wr_q;
        acc_oob    = {2'b00, acc_word} >= DEPTH_WORDS;
        acc_err    = (acc_rd & acc_wr) | acc_oob;
        acc_idx    = acc_word[IdxW-1:0];
        enter_done = (state_d == StDone);
        mem_we     = enter_done & acc_wr & ~acc_err & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (from_idle && (dmem_read || dmem_write)) begin
                word_q  <= dmem_addr[31:2];
                wdata_q <= dmem_data_out;
                be_q    <= dmem_byte_enable;
                rd_q    <= dmem_read;
                wr_q    <= dmem_write;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_in_q <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ready_q <= enter_done;
            error_q <= enter_done & acc_err;
            if (enter_done && acc_rd) begin
                data_in_q <= acc_err ? 32'd0 : mem_q[acc_idx];
            end
        end
    end

    // RAM contents survive reset; only enabled lanes are committed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_data_in = data_in_q;
    assign dmem_ready   = ready_q;
    assign dmem_error   = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a transaction-level memory model predicts
// each completion; a monitor pops and checks every ready pulse, including its latency.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;
    localparam int unsigned NW    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_data_out = '0;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [3:0]  dmem_byte_enable = '0;
    logic [31:0] dmem_data_in;
    logic        dmem_ready;
    logic        dmem_error;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_addr        (dmem_addr),
        .dmem_data_out    (dmem_data_out),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_data_in     (dmem_data_in),
        .dmem_ready       (dmem_ready),
        .dmem_error       (dmem_error)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd = '0;
    bit          in_done = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dmem_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", 32'(dmem_ready), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("error", 32'(dmem_error), 32'(mon_e.err));
                    chk("rdata", dmem_data_in, mon_e.data);
                    chk("latency_edge", 32'(edge_cnt), 32'(mon_e.due));
                end
            end else if (dmem_error) begin
                chk("error_outside_ready", 32'(dmem_error), 32'd0);
            end
        end
    end

    // Transaction-level prediction: what the initiator should see when this access completes.
    task automatic predict(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        int unsigned word = addr >> 2;
        logic [31:0] w;
        e.err  = 1'b0;
        if ((rd && wr) || word >= DEPTH) begin
            e.err = 1'b1;
            if (rd) last_rd = 32'd0;
        end else if (wr) begin
            w = ref_mem.exists(word) ? ref_mem[word] : 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (be[3-k]) w[31-8*k -: 8] = wdata[31-8*k -: 8];
            end
            ref_mem[word] = w;
        end else begin
            last_rd = ref_mem[word];
        end
        e.data = last_rd;
    endtask

    // Called at a negedge; issues and holds the request until the ready pulse is seen.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   t;
        predict(rd, wr, addr, wdata, be, e);
        e.due = edge_cnt + 1 + int'(WS) + (in_done ? 1 : 0);
        sbq.push_back(e);
        dmem_read        = rd;
        dmem_write       = wr;
        dmem_addr        = addr;
        dmem_data_out    = wdata;
        dmem_byte_enable = be;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dmem_ready && t < 50);
        if (!dmem_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no dmem_ready after %0d cycles, required within %0d", t, WS + 2);
            summary();
            $finish;
        end
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        in_done    = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_data_in", dmem_data_in, 32'd0);
        chk("reset_ready", 32'(dmem_ready), 32'd0);
        chk("reset_error", 32'(dmem_error), 32'd0);
        reset = 1'b0;
        idle();

        // Full-word write then read back.
        access(1'b0, 1'b1, 32'h0, 32'hCAFEBABE, 4'b1111); idle();
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000); idle();

        // Byte lanes: expect 0xFF00FFFF.
        access(1'b0, 1'b1, 32'h0, 32'h0000_0000, 4'b1111);
        access(1'b0, 1'b1, 32'h0, 32'hFF00_0000, 4'b1000);
        access(1'b0, 1'b1, 32'h2, 32'h0000_FFFF, 4'b0011);
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000); idle();

        for (int w = 1; w < int'(NW); w++) begin
            access(1'b0, 1'b1, 32'(w) << 2, $urandom, 4'b1111);
        end
        idle();

        // Error cases: out-of-range read, read+write together, then verify word untouched.
        access(1'b1, 1'b0, DEPTH << 2, 32'h0, 4'b0000); idle();
        access(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000); idle();
        access(1'b1, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'b1111); idle();
        access(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000); idle();
        access(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 4'b1111); idle();

        // Zero byte-enable write is a no-op that keeps the last read data.
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000); idle();
        access(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0000); idle();
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000); idle();

        // Reset during WAIT aborts the write.
        dmem_write = 1'b1; dmem_addr = 32'h8; dmem_data_out = 32'h1234_5678;
        dmem_byte_enable = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_data_in", dmem_data_in, 32'd0);
        chk("abort_ready", 32'(dmem_ready), 32'd0);
        chk("abort_error", 32'(dmem_error), 32'd0);
        dmem_write = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(); idle();
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000); idle();

        for (int i = 0; i < 300; i++) begin
            int unsigned op = $urandom_range(0, 9);
            logic [31:0] a = {26'($urandom_range(0, NW - 1)), 2'($urandom), 2'b00} >> 2;
            a = {a[29:0], 2'($urandom)};
            if (op == 9) a = ((DEPTH + $urandom_range(0, 500)) << 2) | 32'($urandom_range(0, 3));
            unique case (op)
                0, 1, 2, 3: access(1'b1, 1'b0, a, $urandom, 4'($urandom));
                8:          access(1'b1, 1'b1, a, $urandom, 4'($urandom));
                9:          access(op[0], ~op[0] | $urandom_range(0, 1) == 0, a, $urandom,
                                   4'($urandom));
                default:    access(1'b0, 1'b1, a, $urandom, 4'($urandom));
            endcase
            if ($urandom_range(0, 2) == 0) idle();
        end

        idle();
        repeat (WS + 4) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
